mult_div_unit: RTL and testbench
================================

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 SHALL have parameter MULT_CYCLES, default 5, busy duration of mult/multu in cycles.
REQ-002 SHALL have parameter DIV_CYCLES, default 10, busy duration of div/divu in cycles.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-005 SHALL have port MDU_i_Start, input, 1, E-stage request strobe, qualifies MDU_i_Op for one cycle.
REQ-006 SHALL have port MDU_i_Op, input, 4, operation: 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo; other codes are no-op.
REQ-007 SHALL have port MDU_i_A, input, 32, rs operand (forwarded value).
REQ-008 SHALL have port MDU_i_B, input, 32, rt operand (forwarded value).
REQ-009 SHALL have port MDU_o_Busy, output, 1, registered, high while a mult/div is in flight; feeds the hazard unit's E-stage MDU busy input.
REQ-010 SHALL have port MDU_o_HI, output, 32, committed HI register (mfhi source).
REQ-011 SHALL have port MDU_o_LO, output, 32, committed LO register (mflo source).

Function
REQ-012 SHALL have states IDLE and RUN; a request is accepted only when MDU_i_Start=1 in IDLE.
REQ-013 SHALL on accepted mult/multu capture the 64-bit product (signed/unsigned) into internal result registers, load counter with MULT_CYCLES, and enter RUN at the same edge.
REQ-014 SHALL on accepted div/divu with MDU_i_B!=0 capture quotient to result-LO and remainder to result-HI, load counter with DIV_CYCLES, and enter RUN.
REQ-015 SHALL for signed div truncate quotient toward zero, remainder takes dividend's sign; 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
REQ-016 SHALL on div/divu with MDU_i_B==0 still run DIV_CYCLES busy cycles but leave HI/LO unchanged at commit.
REQ-017 SHALL assert MDU_o_Busy at the edge entering RUN and hold it for exactly N cycles (N = MULT_CYCLES or DIV_CYCLES); counter decrements each RUN cycle.
REQ-018 SHALL at the edge where counter reaches 1 in RUN: write result registers to HI/LO, deassert MDU_o_Busy, return to IDLE (same edge).
REQ-019 SHALL keep MDU_o_HI/MDU_o_LO at previous committed values throughout RUN (no partial results visible).
REQ-020 SHALL on accepted mthi/mtlo write MDU_i_A to HI/LO respectively at the next edge, no busy, stay IDLE.
REQ-021 SHALL ignore MDU_i_Start (any op) while in RUN; no state, counter or result change.
REQ-022 SHALL treat unused Op codes (0, 7-15) with Start=1 as no-op in IDLE.
REQ-023 SHALL accept a new request in the cycle immediately after Busy falls (back-to-back allowed, no bubble).
REQ-024 SHALL never expose the request cycle itself as Busy; the hazard unit covers that cycle via the E-stage MDU-usage decode.

Reset
REQ-025 SHALL on reset=1 at an edge set HI=0, LO=0, result registers=0, counter=0, MDU_o_Busy=0, state IDLE.
REQ-026 SHALL on reset mid-RUN discard the in-flight result; reset dominates a simultaneous Start.

Verification
REQ-027 SHALL verify mult: A=0xFFFFFFFF, B=0x00000002, Start 1 cycle -> Busy high exactly 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFE; multu same operands -> HI=0x00000001, LO=0xFFFFFFFE.
REQ-028 SHALL verify div: A=0xFFFFFFF9 (-7), B=2 -> Busy 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF; divu A=7, B=2 -> LO=3, HI=1.
REQ-029 SHALL verify div by zero: HI=0x11, LO=0x22 preset via mthi/mtlo, div A=5, B=0 -> Busy 10 cycles, HI=0x11, LO=0x22 after.
REQ-030 SHALL verify Start (mult) during RUN of a div -> ignored; div result committed at its own 10th cycle, Busy falls then.
REQ-031 SHALL verify reset asserted on 3rd cycle of mult -> next cycle Busy=0, HI=LO=0; no later commit.
REQ-032 SHALL verify mtlo A=0xDEADBEEF in IDLE -> LO=0xDEADBEEF next cycle, Busy stays 0; back-to-back mult issued the cycle after a commit is accepted.

Source files
------------

// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit with committed HI/LO registers.
// Results are computed at request time and held privately until the busy window ends.
module mult_div_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MDU_i_Start,
    input  logic [3:0]  MDU_i_Op,
    input  logic [31:0] MDU_i_A,
    input  logic [31:0] MDU_i_B,
    output logic        MDU_o_Busy,
    output logic [31:0] MDU_o_HI,
    output logic [31:0] MDU_o_LO
);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;

    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   res_hi_q, res_hi_d;
    logic [31:0]   res_lo_q, res_lo_d;
    logic [31:0]   hi_q, hi_d;
    logic [31:0]   lo_q, lo_d;
    logic          wr_q, wr_d;
    logic          busy_q, busy_d;

    // Signed ops run on magnitudes through one unsigned datapath, then fix signs.
    logic        is_signed, neg_res, neg_rem;
    logic [31:0] mag_a, mag_b, div_b;
    logic [63:0] prod_mag, prod;
    logic [31:0] quot_mag, rem_mag, quot, rem;

    always_comb begin
        is_signed = (MDU_i_Op == OP_MULT) || (MDU_i_Op == OP_DIV);
        neg_res   = is_signed && (MDU_i_A[31] ^ MDU_i_B[31]);
        neg_rem   = is_signed && MDU_i_A[31];
        mag_a     = (is_signed && MDU_i_A[31]) ? (~MDU_i_A + 32'd1) : MDU_i_A;
        mag_b     = (is_signed && MDU_i_B[31]) ? (~MDU_i_B + 32'd1) : MDU_i_B;
        div_b     = (mag_b == 32'd0) ? 32'd1 : mag_b;
        prod_mag  = {32'd0, mag_a} * {32'd0, mag_b};
        prod      = neg_res ? (~prod_mag + 64'd1) : prod_mag;
        quot_mag  = mag_a / div_b;
        rem_mag   = mag_a % div_b;
        quot      = neg_res ? (~quot_mag + 32'd1) : quot_mag;
        rem       = neg_rem ? (~rem_mag + 32'd1) : rem_mag;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        res_hi_d = res_hi_q;
        res_lo_d = res_lo_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        wr_d     = wr_q;
        busy_d   = busy_q;
        case (state_q)
            IDLE: begin
                if (MDU_i_Start) begin
                    case (MDU_i_Op)
                        OP_MULT, OP_MULTU: begin
                            res_hi_d = prod[63:32];
                            res_lo_d = prod[31:0];
                            wr_d     = 1'b1;
                            cnt_d    = CW'(MULT_CYCLES);
                            state_d  = RUN;
                            busy_d   = 1'b1;
                        end
                        OP_DIV, OP_DIVU: begin
                            // Divide by zero still occupies the unit but commits nothing.
                            if (MDU_i_B != 32'd0) begin
                                res_hi_d = rem;
                                res_lo_d = quot;
                            end
                            wr_d    = (MDU_i_B != 32'd0);
                            cnt_d   = CW'(DIV_CYCLES);
                            state_d = RUN;
                            busy_d  = 1'b1;
                        end
                        OP_MTHI: hi_d = MDU_i_A;
                        OP_MTLO: lo_d = MDU_i_A;
                        default: ;
                    endcase
                end
            end
            RUN: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    if (wr_q) begin
                        hi_d = res_hi_q;
                        lo_d = res_lo_q;
                    end
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            res_hi_q <= '0;
            res_lo_q <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            wr_q     <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            res_hi_q <= res_hi_d;
            res_lo_q <= res_lo_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            wr_q     <= wr_d;
            busy_q   <= busy_d;
        end
    end

    assign MDU_o_Busy = busy_q;
    assign MDU_o_HI   = hi_q;
    assign MDU_o_LO   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: directed literal cases plus randomized traffic
// compared every cycle against an arithmetic model of HI/LO/Busy.
module tb_mult_div_unit;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk;
    logic        reset;
    logic        start;
    logic [3:0]  op;
    logic [31:0] a, b;
    logic        busy;
    logic [31:0] hi, lo;

    mult_div_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk        (clk),
        .reset      (reset),
        .MDU_i_Start(start),
        .MDU_i_Op   (op),
        .MDU_i_A    (a),
        .MDU_i_B    (b),
        .MDU_o_Busy (busy),
        .MDU_o_HI   (hi),
        .MDU_o_LO   (lo)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // behavioural model: busy time remaining and the value to commit when it runs out
    logic [31:0] m_hi, m_lo, m_ph, m_pl;
    int          m_left;
    bit          m_pv;

    always @(posedge clk) begin
        longint          sp, sq, sr;
        longint unsigned up;
        if (reset) begin
            m_hi = 0; m_lo = 0; m_left = 0; m_pv = 0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0 && m_pv) begin
                m_hi = m_ph;
                m_lo = m_pl;
            end
        end else if (start) begin
            case (op)
                4'd1: begin
                    sp = longint'($signed(a)) * longint'($signed(b));
                    m_ph = sp[63:32]; m_pl = sp[31:0]; m_pv = 1; m_left = MC;
                end
                4'd2: begin
                    up = longint'(a) * longint'(b);
                    m_ph = up[63:32]; m_pl = up[31:0]; m_pv = 1; m_left = MC;
                end
                4'd3: begin
                    m_left = DC; m_pv = (b != 0);
                    if (b != 0) begin
                        sq = longint'($signed(a)) / longint'($signed(b));
                        sr = longint'($signed(a)) % longint'($signed(b));
                        m_pl = sq[31:0]; m_ph = sr[31:0];
                    end
                end
                4'd4: begin
                    m_left = DC; m_pv = (b != 0);
                    if (b != 0) begin
                        m_pl = a / b; m_ph = a % b;
                    end
                end
                4'd5: m_hi = a;
                4'd6: m_lo = a;
                default: ;
            endcase
        end
    end

    // scoreboard compare, every cycle once out of the first reset
    always @(negedge clk) begin
        if (chk_en) begin
            check("busy", {31'd0, busy}, {31'd0, (m_left > 0)});
            check("hi", hi, m_hi);
            check("lo", lo, m_lo);
        end
    end

    // driver tasks: all run in the phase just after a rising edge
    task automatic step();
        @(posedge clk); #2;
    endtask

    task automatic issue(input logic [3:0] o, input logic [31:0] va, input logic [31:0] vb);
        start = 1'b1; op = o; a = va; b = vb;
        step();
        start = 1'b0; op = 4'd0;
    endtask

    task automatic run_count(output int n);
        n = 0;
        for (int i = 0; i < 100; i++) begin
            if (!busy) break;
            n++;
            step();
        end
    endtask

    function automatic logic [31:0] pick_val();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int n;
        reset = 1'b1; start = 1'b0; op = 4'd0; a = 0; b = 0;
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
        chk_en = 1'b1;
        check("rst_hi", hi, 32'h0);
        check("rst_lo", lo, 32'h0);
        check("rst_busy", {31'd0, busy}, 32'd0);

        issue(4'd1, 32'hFFFF_FFFF, 32'h2);
        run_count(n);
        check("mult_cycles", n, MC);
        check("mult_hi", hi, 32'hFFFF_FFFF);
        check("mult_lo", lo, 32'hFFFF_FFFE);

        issue(4'd2, 32'hFFFF_FFFF, 32'h2);
        run_count(n);
        check("multu_b2b_cycles", n, MC);
        check("multu_hi", hi, 32'h0000_0001);
        check("multu_lo", lo, 32'hFFFF_FFFE);

        issue(4'd3, 32'hFFFF_FFF9, 32'h2);
        run_count(n);
        check("div_cycles", n, DC);
        check("div_lo", lo, 32'hFFFF_FFFD);
        check("div_hi", hi, 32'hFFFF_FFFF);

        issue(4'd4, 32'd7, 32'd2);
        run_count(n);
        check("divu_lo", lo, 32'd3);
        check("divu_hi", hi, 32'd1);

        issue(4'd5, 32'h11, 32'h0);
        issue(4'd6, 32'h22, 32'h0);
        check("mthi", hi, 32'h11);
        check("mtlo", lo, 32'h22);
        issue(4'd3, 32'd5, 32'd0);
        run_count(n);
        check("div0_cycles", n, DC);
        check("div0_hi", hi, 32'h11);
        check("div0_lo", lo, 32'h22);

        issue(4'd6, 32'hDEAD_BEEF, 32'h0);
        check("mtlo_dead", lo, 32'hDEAD_BEEF);
        check("mtlo_busy", {31'd0, busy}, 32'd0);

        issue(4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        run_count(n);
        check("ovf_lo", lo, 32'h8000_0000);
        check("ovf_hi", hi, 32'h0);

        issue(4'd3, 32'd100, 32'd7);
        step();
        step();
        issue(4'd1, 32'd3, 32'd3);
        run_count(n);
        check("ignored_start_rest", n, DC - 3);
        check("ignored_hi", hi, 32'd2);
        check("ignored_lo", lo, 32'd14);

        issue(4'd1, 32'd5, 32'd6);
        step();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_hi", hi, 32'h0);
        check("midrst_lo", lo, 32'h0);
        repeat (8) step();
        check("midrst_nocommit_lo", lo, 32'h0);

        for (int i = 0; i < 3000; i++) begin
            start = ($urandom_range(0, 2) == 0);
            op    = 4'($urandom_range(0, 8) == 8 ? $urandom_range(0, 15) : $urandom_range(0, 7));
            a     = pick_val();
            b     = pick_val();
            reset = ($urandom_range(0, 99) == 0);
            step();
        end
        start = 1'b0; reset = 1'b0;
        repeat (12) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
